// File: rtl/page_pkg.sv
// Shared pager-link definitions: states, line levels, defaults.
// Used by both the transmitter and the receiver side.
package page_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_GUARD    = 2'd3
    } page_state_e;

    localparam logic X_IDLE = 1'b1;
    localparam logic X_PRE  = 1'b0;

    localparam int DATA_W_DEF     = 8;
    localparam int PRE_LEN_DEF    = 3;
    localparam int GUARD_LEN_DEF  = 2;
    localparam int BIT_CYCLES_DEF = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/page_bit_timer.sv
// Serial bit timer: counts 0..BIT_CYCLES-1 while enabled.
// tick is high on the last cycle of each bit.
module page_bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    logic [TW-1:0] cnt_q;

    assign tick = enable && (cnt_q == TW'(BIT_CYCLES - 1));

    // Free-run within a bit, restart at bit end or when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!enable || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

endmodule

// File: rtl/page_tx.sv
// Pager frame transmitter: preamble zeros, MSB-first payload,
// guard ones; all outputs come straight from flops.
module page_tx
    import page_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PRE_LEN    = PRE_LEN_DEF,
    parameter int GUARD_LEN  = GUARD_LEN_DEF,
    parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DATA_W-1:0] data,
    output logic              x,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(max3(PRE_LEN, DATA_W, GUARD_LEN) + 1);

    page_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic              x_q;
    logic              busy_q;
    logic              rdy_q;
    logic              done_q;
    logic              tick;

    page_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (busy_q),
        .tick   (tick)
    );

    // Payload shifter, MSB leaves first.
    always_comb begin
        shift_d = shift_q << 1;
    end

    // Frame sequencer with registered line and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            x_q     <= X_IDLE;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_valid) begin
                        state_q <= ST_PREAMBLE;
                        cnt_q   <= '0;
                        shift_q <= data;
                        x_q     <= X_PRE;
                        busy_q  <= 1'b1;
                        rdy_q   <= 1'b0;
                    end
                end
                ST_PREAMBLE: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(PRE_LEN - 1)) begin
                            state_q <= ST_PAYLOAD;
                            cnt_q   <= '0;
                            x_q     <= shift_q[DATA_W-1];
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_q <= ST_GUARD;
                            cnt_q   <= '0;
                            shift_q <= '0;
                            x_q     <= X_IDLE;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                            shift_q <= shift_d;
                            x_q     <= shift_d[DATA_W-1];
                        end
                    end
                end
                ST_GUARD: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(GUARD_LEN - 1)) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                            x_q     <= X_IDLE;
                            busy_q  <= 1'b0;
                            rdy_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    x_q     <= X_IDLE;
                    busy_q  <= 1'b0;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign x           = x_q;
    assign busy        = busy_q;
    assign start_ready = rdy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_page_tx.sv
// Directed bench for page_tx: default frame, back-to-back,
// busy request, mid-frame reset, pager loopback, small corner.
module tb_page_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sv, rdy, x, busy, done;
    logic [7:0] d;
    logic       sv2, rdy2, x2, busy2, done2;
    logic [3:0] d2;

    int total = 0;
    int bad   = 0;

    logic [127:0] xs, e_a, e_b;
    int bn, dn, dat, dat2, rl1, rl2, zfirst;
    logic rd53;

    logic [7:0] zcnt;
    logic       z;

    always #5 clk = ~clk;

    page_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (sv),
        .start_ready (rdy),
        .data        (d),
        .x           (x),
        .busy        (busy),
        .done        (done)
    );

    page_tx #(
        .DATA_W     (4),
        .PRE_LEN    (3),
        .GUARD_LEN  (1),
        .BIT_CYCLES (1)
    ) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (sv2),
        .start_ready (rdy2),
        .data        (d2),
        .x           (x2),
        .busy        (busy2),
        .done        (done2)
    );

    // Zero-detect pager: asserts z once x has been low for 9 cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) zcnt <= 8'd0;
        else if (x) zcnt <= 8'd0;
        else if (zcnt != 8'hFF) zcnt <= zcnt + 8'd1;
    end
    assign z = (zcnt >= 8'd9);

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] expand(input logic [15:0] bits,
                                            input int n, input int bc);
        logic [127:0] r;
        r = '0;
        for (int i = n - 1; i >= 0; i--)
            for (int j = 0; j < bc; j++)
                r = {r[126:0], bits[i]};
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        sv = 1'b0; d = 8'h00;
        sv2 = 1'b0; d2 = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_x", x, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", rdy, 1);
        check("rst_done", done, 0);
        check("rst_x2", x2, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // basic A5 frame
        sv = 1'b1; d = 8'hA5;
        @(posedge clk); #1; sv = 1'b0;
        xs = '0; bn = 0; dn = 0; dat = 0; rd53 = 1'b0;
        for (int c = 1; c <= 53; c++) begin
            @(negedge clk);
            if (c <= 52) xs = {xs[126:0], x};
            if (busy) bn++;
            if (done) begin dn++; dat = c; end
            if (c == 53) rd53 = rdy;
        end
        check("a5_x", xs, expand(16'b0001010010111, 13, 4));
        check("a5_busy", bn, 52);
        check("a5_done_n", dn, 1);
        check("a5_done_at", dat, 53);
        check("a5_ready53", rd53, 1);
        @(posedge clk); #1;

        // back-to-back 00 then FF
        sv = 1'b1; d = 8'h00;
        @(posedge clk); #1; d = 8'hFF;
        xs = '0; dn = 0; dat = 0; dat2 = 0; rl1 = 0; rl2 = 0;
        for (int c = 1; c <= 106; c++) begin
            @(negedge clk);
            xs = {xs[126:0], x};
            if (!rdy && c <= 53) rl1++;
            if (!rdy && c > 53) rl2++;
            if (done) begin
                dn++;
                if (dat == 0) dat = c; else dat2 = c;
            end
            if (c == 105) sv = 1'b0;
        end
        e_a = expand(16'b0000000000011, 13, 4);
        e_b = expand(16'b0001111111111, 13, 4);
        check("b2b_x", xs, {22'd0, e_a[51:0], 1'b1, e_b[51:0], 1'b1});
        check("b2b_rl1", rl1, 52);
        check("b2b_rl2", rl2, 52);
        check("b2b_done_n", dn, 2);
        check("b2b_done1", dat, 53);
        check("b2b_done2", dat2, 106);
        @(posedge clk); #1;

        // request while busy is ignored
        sv = 1'b1; d = 8'h3C;
        @(posedge clk); #1; sv = 1'b0;
        xs = '0; bn = 0; dn = 0; dat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c <= 52) xs = {xs[126:0], x};
            if (busy) bn++;
            if (done) begin dn++; dat = c; end
            if (c == 10) begin sv = 1'b1; d = 8'hFF; end
            if (c == 11) begin sv = 1'b0; d = 8'h00; end
        end
        check("busyreq_x", xs, expand(16'b0000011110011, 13, 4));
        check("busyreq_busy", bn, 52);
        check("busyreq_done_n", dn, 1);
        check("busyreq_done_at", dat, 53);
        @(posedge clk); #1;

        // reset mid-frame
        sv = 1'b1; d = 8'h81;
        @(posedge clk); #1; sv = 1'b0;
        dn = 0; bn = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst_n = 1'b0;
        #1;
        check("mrst_x", x, 1);
        check("mrst_busy", busy, 0);
        check("mrst_ready", rdy, 1);
        check("mrst_done", done, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) dn++;
            if (busy) bn++;
        end
        check("mrst_no_done", dn, 0);
        check("mrst_no_replay", bn, 0);
        @(posedge clk); #1;

        // loopback into zero-detect pager
        sv = 1'b1; d = 8'hFF;
        @(posedge clk); #1; sv = 1'b0;
        zfirst = 0; dn = 0;
        for (int c = 1; c <= 53; c++) begin
            @(negedge clk);
            if (z && zfirst == 0) zfirst = c;
            if (done) dn++;
        end
        check("loop_z_bit3", (zfirst >= 9 && zfirst <= 12), 1);
        check("loop_done", dn, 1);
        @(posedge clk); #1;

        // corner: BIT_CYCLES=1, 8-cycle frame
        sv2 = 1'b1; d2 = 4'b1011;
        @(posedge clk); #1; sv2 = 1'b0;
        xs = '0; bn = 0; dn = 0; dat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c <= 8) xs = {xs[126:0], x2};
            if (busy2) bn++;
            if (done2) begin dn++; dat = c; end
        end
        check("corner_x", xs, 128'b00010111);
        check("corner_busy", bn, 8);
        check("corner_done_at", dat, 9);
        check("corner_done_n", dn, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
